// File: rtl/fnn_pkg.sv
// Shared definitions for the fnn datapath blocks: argmax FSM encoding,
// a constant clog2 helper and the default score width.
package fnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fnn_argmax_cmp.sv
// Combinational signed compare-and-select: the candidate replaces the current
// best only when strictly greater, so on ties the incumbent is kept.
module fnn_argmax_cmp
  import fnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IDX_W      = 1
) (
  input  logic [DATA_WIDTH-1:0] cand_val,
  input  logic [IDX_W-1:0]      cand_idx,
  input  logic [DATA_WIDTH-1:0] best_val,
  input  logic [IDX_W-1:0]      best_idx,
  output logic [DATA_WIDTH-1:0] next_val,
  output logic [IDX_W-1:0]      next_idx
);

  logic take;

  assign take     = $signed(cand_val) > $signed(best_val);
  assign next_val = take ? cand_val : best_val;
  assign next_idx = take ? cand_idx : best_idx;

endmodule

// File: rtl/fnn_argmax.sv
// Sequential argmax over the packed fnn output vector, one score per cycle.
// Optional threshold/reject port pair is enabled by FNN_ARGMAX_THRESH_EN.
module fnn_argmax
  import fnn_pkg::*;
#(
  parameter int OUTPUTS    = 2,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int IDX_W     = (clog2(OUTPUTS) > 1) ? clog2(OUTPUTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [OUTPUTS*DATA_WIDTH-1:0] in_vector,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              out_index,
  output logic [DATA_WIDTH-1:0]         out_value
`ifdef FNN_ARGMAX_THRESH_EN
  ,
  input  logic [DATA_WIDTH-1:0]         thresh,
  output logic                          out_reject
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(OUTPUTS - 1);
  localparam logic [IDX_W-1:0] FIRST_SCAN = (OUTPUTS > 1) ? IDX_W'(1) : '0;

  argmax_state_t state, state_next;

  logic [DATA_WIDTH-1:0] vec_q [OUTPUTS];
  logic [IDX_W-1:0]      cnt;
  logic [IDX_W-1:0]      best_idx;
  logic [DATA_WIDTH-1:0] best_val;
  logic [DATA_WIDTH-1:0] scan_val;
  logic [IDX_W-1:0]      scan_idx;

  fnn_argmax_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_scan_cmp (
    .cand_val (vec_q[cnt]),
    .cand_idx (cnt),
    .best_val (best_val),
    .best_idx (best_idx),
    .next_val (scan_val),
    .next_idx (scan_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (OUTPUTS > 1) state_next = SCAN;
          else             state_next = DONE;
        end
      end
      SCAN: begin
        if (cnt == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Scans only the captured copy so in_vector is free to change after accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < OUTPUTS; i++) vec_q[i] <= '0;
      cnt      <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        for (int i = 0; i < OUTPUTS; i++) vec_q[i] <= in_vector[i*DATA_WIDTH +: DATA_WIDTH];
        best_val <= in_vector[DATA_WIDTH-1:0];
        best_idx <= '0;
        cnt      <= FIRST_SCAN;
      end
    end else if (state == SCAN) begin
      best_val <= scan_val;
      best_idx <= scan_idx;
      if (cnt != LAST_IDX) cnt <= cnt + IDX_W'(1);
    end
  end

  assign out_index = best_idx;
  assign out_value = best_val;

`ifdef FNN_ARGMAX_THRESH_EN
  logic [DATA_WIDTH-1:0] thresh_q;
  logic [DATA_WIDTH-1:0] thr_val;
  logic [DATA_WIDTH-1:0] thr_ref;
  logic [DATA_WIDTH-1:0] thr_max_unused;
  logic                  thr_rej;
  logic                  rej_q;

  // Threshold as candidate index 1 against the best as index 0: index 1 wins
  // exactly when best < thresh, which is the reject condition.
  assign thr_val = (state == SCAN) ? scan_val : in_vector[DATA_WIDTH-1:0];
  assign thr_ref = (state == SCAN) ? thresh_q : thresh;

  fnn_argmax_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (1)
  ) u_thr_cmp (
    .cand_val (thr_ref),
    .cand_idx (1'b1),
    .best_val (thr_val),
    .best_idx (1'b0),
    .next_val (thr_max_unused),
    .next_idx (thr_rej)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      thresh_q <= '0;
      rej_q    <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        thresh_q <= thresh;
        rej_q    <= thr_rej;
      end
    end else if (state == SCAN) begin
      rej_q <= thr_rej;
    end
  end

  assign out_reject = rej_q;
`endif

endmodule

// File: tb/tb_fnn_argmax.sv
// Scoreboard bench for fnn_argmax with OUTPUTS=4, DATA_WIDTH=16.
// Define FNN_ARGMAX_THRESH_EN to also exercise thresh/out_reject.
module tb_fnn_argmax;

  localparam int OUTPUTS = 4;
  localparam int DW      = 16;
  localparam logic [DW-1:0] TH_MIN = 16'h8000;

  typedef struct packed {
    logic [1:0]    idx;
    logic [DW-1:0] val;
    logic          rej;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [OUTPUTS*DW-1:0] in_vector = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [1:0]            out_index;
  logic [DW-1:0]         out_value;
  logic [DW-1:0]         thresh = '0;
`ifdef FNN_ARGMAX_THRESH_EN
  logic                  out_reject;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  fnn_argmax #(
    .OUTPUTS    (OUTPUTS),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vector  (in_vector),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_value  (out_value)
`ifdef FNN_ARGMAX_THRESH_EN
    ,
    .thresh     (thresh),
    .out_reject (out_reject)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic exp_t model(input logic [OUTPUTS*DW-1:0] v, input logic [DW-1:0] th);
    exp_t e;
    logic [DW-1:0] x;
    e.idx = '0;
    e.val = v[DW-1:0];
    for (int i = 1; i < OUTPUTS; i++) begin
      x = v[i*DW +: DW];
      if ($signed(x) > $signed(e.val)) begin
        e.val = x;
        e.idx = 2'(i);
      end
    end
    e.rej = $signed(e.val) < $signed(th);
    return e;
  endfunction

  // Wait for in_ready, present one vector for a single accept edge, then scramble in_vector.
  task automatic applyStimulus(input logic [OUTPUTS*DW-1:0] vec, input logic [DW-1:0] th, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    in_vector = vec;
    thresh    = th;
    in_valid  = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_vector = {$urandom, $urandom};
    thresh    = 16'($urandom);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("result_index", 32'(out_index), 32'(e.idx));
        checkOutput("result_value", 32'(out_value), 32'(e.val));
`ifdef FNN_ARGMAX_THRESH_EN
        checkOutput("result_reject", 32'(out_reject), 32'(e.rej));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t ea;
    logic [OUTPUTS*DW-1:0] v;
    logic [DW-1:0] th;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_index", 32'(out_index), 32'd0);
    checkOutput("reset_out_value", 32'(out_value), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    // Basic with latency and single-cycle out_valid
    applyStimulus(64'h0004_0003_0002_0001, TH_MIN, '{idx: 2'd3, val: 16'h0004, rej: 1'b0});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("basic_valid_c%0d", k), 32'(out_valid), (k == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    checkOutput("basic_valid_drop", 32'(out_valid), 32'd0);
    checkOutput("basic_ready_back", 32'(in_ready), 32'd1);

    // Tie and signed corners
    applyStimulus(64'h0005_0007_0007_0002, TH_MIN, '{idx: 2'd1, val: 16'h0007, rej: 1'b0});
    applyStimulus(64'hFFFF_FFFE_FFF0_8000, TH_MIN, '{idx: 2'd3, val: 16'hFFFF, rej: 1'b0});
    applyStimulus(64'h0001_8000_7FFF_0000, TH_MIN, '{idx: 2'd1, val: 16'h7FFF, rej: 1'b0});
    applyStimulus(64'h8000_8000_8000_8000, TH_MIN, '{idx: 2'd0, val: 16'h8000, rej: 1'b0});
    waitDrain();

    // Backpressure: result held while a new vector waits on in_valid
    out_ready = 1'b0;
    applyStimulus(64'h0010_0030_0020_0001, TH_MIN, '{idx: 2'd2, val: 16'h0030, rej: 1'b0});
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp_reach_done", 32'(out_valid), 32'd1);
    in_vector = 64'h0100_0001_0002_0003;
    thresh    = TH_MIN;
    in_valid  = 1'b1;
    sb.push_back('{idx: 2'd3, val: 16'h0100, rej: 1'b0});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_valid_held", 32'(out_valid), 32'd1);
      checkOutput("bp_index_held", 32'(out_index), 32'd2);
      checkOutput("bp_value_held", 32'(out_value), 32'h0030);
      checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("bp_ready_rise", 32'(in_ready), 32'd1);
    checkOutput("bp_valid_drop", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("bp_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    waitDrain();

    // Reset one cycle after accept abandons the scan
    applyStimulus(64'h0040_0050_0060_0070, TH_MIN, '{idx: 2'd0, val: 16'h0070, rej: 1'b0});
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_scan_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_scan_index", 32'(out_index), 32'd0);
    checkOutput("rst_scan_value", 32'(out_value), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_scan_ready", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    applyStimulus(64'h0003_0009_0001_0002, TH_MIN, '{idx: 2'd2, val: 16'h0009, rej: 1'b0});
    waitDrain();

`ifdef FNN_ARGMAX_THRESH_EN
    applyStimulus(64'h0004_0003_0002_0001, 16'h0005, '{idx: 2'd3, val: 16'h0004, rej: 1'b1});
    applyStimulus(64'h0004_0003_0002_0001, 16'h0004, '{idx: 2'd3, val: 16'h0004, rej: 1'b0});
    applyStimulus(64'hFFF0_FFF1_FFF2_FFF3, 16'hFFFF, '{idx: 2'd0, val: 16'hFFF3, rej: 1'b1});
    waitDrain();
`endif

    // Random vectors back to back, checked against the reference model
    for (int r = 0; r < 8; r++) begin
      v  = {$urandom, $urandom};
      th = 16'($urandom);
      applyStimulus(v, th, model(v, th));
    end
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnn_argmax.md
Name: fnn_argmax

Overview:
- Classification stage directly downstream of fnn; consumes the packed output_vector of OUTPUTS signed scores.
- Scans the scores sequentially, one per cycle, and returns the winning class index and its score over a valid/ready handshake.
- Lets fnn results feed control logic without a wide combinational compare tree.

Parameters:
- OUTPUTS, 2, number of scores in the input vector (>=1).
- DATA_WIDTH, 16, width of each score, signed two's complement.
- IDX_W, derived localparam = max(1, clog2(OUTPUTS)), width of the class index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  in_vector holds a complete score vector.
- in_ready  out  1  block can accept a vector.
- in_vector  in  OUTPUTS*DATA_WIDTH  packed scores; element i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_index  out  IDX_W  index of the maximum score.
- out_value  out  DATA_WIDTH  maximum score.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; in_ready=1 after release; out_valid=0, out_index=0, out_value=0; scan counter and captured vector cleared. Reset mid-scan or mid-DONE abandons the result; nothing is emitted.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_vector into an internal register; best_val=elem0, best_idx=0, cnt=1.
  - Next state is SCAN if OUTPUTS>1, else DONE.
  - in_vector is ignored without a handshake.
- SCAN:
  - in_ready=0.
  - Each cycle: if $signed(elem[cnt]) > $signed(best_val), then best_val=elem[cnt] and best_idx=cnt.
  - cnt++. After processing elem[OUTPUTS-1], go to DONE.
  - Reads only the captured copy; in_vector may change freely.
- DONE:
  - out_valid=1; out_index/out_value are registered and held stable.
  - in_ready=0.
  - On out_valid&&out_ready: out_valid=0 next cycle, go to IDLE, in_ready=1 next cycle.
- Latency: acceptance edge at t; out_valid is high after edge t+max(1, OUTPUTS-1).
- Throughput: one vector per max(1, OUTPUTS-1)+2 cycles when out_ready is held high. No overlap between result hold and the next accept.
- Ties: strict greater-than, so the lowest index wins.
- Compare is signed: 16'h8000 is the minimum and 16'h7FFF is the maximum.
- cnt never wraps: it stops at OUTPUTS-1, and the counter width is sized to hold OUTPUTS-1.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored and the vector is not queued.

Optional Feature:
- Macro FNN_ARGMAX_THRESH_EN.
- Defined:
  - Adds port thresh (in, DATA_WIDTH, signed), sampled at the input handshake.
  - Adds port out_reject (out, 1), valid with out_valid.
  - out_reject=1 iff best_val < captured thresh (signed compare).
  - out_reject resets to 0 and is held with out_index.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Shared package fnn_pkg holds:
  - FSM state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - a clog2 constant function;
  - default DATA_WIDTH.
- One sub-module, fnn_argmax_cmp: a combinational signed compare-and-select.
  - Inputs: candidate value/index and current best value/index.
  - Outputs: next best value/index.
  - Reused for the threshold compare.

Test Plan (OUTPUTS=4, DATA_WIDTH=16; vectors listed high element to low):
- Basic: in_vector={0004,0003,0002,0001} with out_ready=1 -> out_index=3, out_value=0x0004; out_valid high 3 cycles after the accept edge for exactly 1 cycle; in_ready returns the following cycle.
- Tie: {0005,0007,0007,0002} -> out_index=1, out_value=0x0007.
- Signed: {FFFF,FFFE,FFF0,8000} -> out_index=3, out_value=0xFFFF. Separately, {0001,8000,7FFF,0000} -> out_index=1, out_value=0x7FFF.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a new vector.
  - Required: out_valid stays high, result stable, in_ready=0, new vector not taken.
  - Then out_ready=1: accept occurs one cycle after in_ready rises.
- Reset mid-scan:
  - Assert rst=0 one cycle after the accept edge.
  - Required: next cycle out_valid=0, out_index=0, out_value=0, no result emitted; after release, in_ready=1 and a fresh vector processes correctly.
- With FNN_ARGMAX_THRESH_EN:
  - thresh=0x0005, vector {0004,0003,0002,0001} -> out_reject=1, out_index=3.
  - thresh=0x0004, same vector -> out_reject=0.
